// File: rtl/sample_averager_if.sv
// Valid/ready bundle between an SPI read-word source and the sample averager.
// The averager takes the slave side, the word source and result sink take the master side.
interface sample_averager_if #(
  parameter int unsigned DATA_WIDTH = 12
);
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [31:0]           in_data_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [DATA_WIDTH-1:0] out_ch0_o;
  logic [DATA_WIDTH-1:0] out_ch1_o;

  modport slave (
    input  in_valid_i,
    input  in_data_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o,
    output out_ch0_o,
    output out_ch1_o
  );

  modport master (
    output in_valid_i,
    output in_data_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o,
    input  out_ch0_o,
    input  out_ch1_o
  );
endinterface

// File: rtl/sample_averager.sv
// Two-channel sample averager: sums 2^LOG2_N SPI read words per channel and presents the
// round-half-up mean pair, holding it until the downstream side takes it.
module sample_averager #(
  parameter int unsigned DATA_WIDTH = 12, // at most 15 so both channels fit a 16-bit half-word
  parameter int unsigned LOG2_N     = 4   // 0..8
) (
  input logic              clk_i,
  input logic              rst_n_i,
  sample_averager_if.slave bus
);

  localparam int unsigned AccWidth   = DATA_WIDTH + LOG2_N;
  localparam int unsigned CntWidth   = LOG2_N + 1;
  localparam int unsigned NumSamples = 1 << LOG2_N;

  // Half an LSB of the result; shifting N right by one gives 0 when N is 1.
  localparam logic [AccWidth:0]     Round   = (AccWidth + 1)'(NumSamples >> 1);
  localparam logic [CntWidth-1:0]   LastCnt = CntWidth'(NumSamples - 1);
  localparam logic [DATA_WIDTH-1:0] MaxVal  = '1;

  typedef enum logic [0:0] {
    StAccum,
    StHold
  } state_e;

  state_e                state_q;
  logic [AccWidth-1:0]   acc0_q;
  logic [AccWidth-1:0]   acc1_q;
  logic [CntWidth-1:0]   cnt_q;
  logic [DATA_WIDTH-1:0] ch0_q;
  logic [DATA_WIDTH-1:0] ch1_q;

  logic [DATA_WIDTH-1:0] samp0;
  logic [DATA_WIDTH-1:0] samp1;
  logic [AccWidth-1:0]   sum0;
  logic [AccWidth-1:0]   sum1;
  logic [DATA_WIDTH-1:0] avg0;
  logic [DATA_WIDTH-1:0] avg1;
  logic                  in_xfer;
  logic                  out_xfer;
  logic                  last_sample;

  // Each converter drives a leading tri-state bit, so its field starts one bit up.
  assign samp0 = bus.in_data_i[DATA_WIDTH:1];
  assign samp1 = bus.in_data_i[16+DATA_WIDTH:17];

  logic unused_bits;
  if (DATA_WIDTH < 15) begin : gen_unused_wide
    assign unused_bits = ^{bus.in_data_i[31:17+DATA_WIDTH], bus.in_data_i[16:DATA_WIDTH+1],
                           bus.in_data_i[0]};
  end else begin : gen_unused_narrow
    assign unused_bits = ^{bus.in_data_i[16], bus.in_data_i[0]};
  end

  // N full-scale samples fit the accumulator exactly, so the running sum cannot wrap.
  assign sum0 = acc0_q + AccWidth'(samp0);
  assign sum1 = acc1_q + AccWidth'(samp1);

  function automatic logic [DATA_WIDTH-1:0] round_mean(input logic [AccWidth-1:0] sum);
    logic [AccWidth:0] rounded;
    logic [AccWidth:0] shifted;
    rounded = {1'b0, sum} + Round;
    shifted = rounded >> LOG2_N;
    if (shifted > (AccWidth + 1)'(MaxVal)) begin
      return MaxVal;
    end
    return shifted[DATA_WIDTH-1:0];
  endfunction

  assign avg0 = round_mean(sum0);
  assign avg1 = round_mean(sum1);

  assign in_xfer     = bus.in_valid_i && (state_q == StAccum);
  assign out_xfer    = bus.out_ready_i && (state_q == StHold);
  assign last_sample = (cnt_q == LastCnt);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StAccum;
      acc0_q  <= '0;
      acc1_q  <= '0;
      cnt_q   <= '0;
      ch0_q   <= '0;
      ch1_q   <= '0;
    end else begin
      case (state_q)
        StAccum: begin
          if (in_xfer) begin
            acc0_q <= sum0;
            acc1_q <= sum1;
            cnt_q  <= cnt_q + CntWidth'(1);
            if (last_sample) begin
              ch0_q   <= avg0;
              ch1_q   <= avg1;
              state_q <= StHold;
            end
          end
        end
        StHold: begin
          // Input words are refused here; only the downstream take releases the pair.
          if (out_xfer) begin
            acc0_q  <= '0;
            acc1_q  <= '0;
            cnt_q   <= '0;
            state_q <= StAccum;
          end
        end
        default: begin
          state_q <= StAccum;
        end
      endcase
    end
  end

  assign bus.in_ready_o  = (state_q == StAccum);
  assign bus.out_valid_o = (state_q == StHold);
  assign bus.out_ch0_o   = ch0_q;
  assign bus.out_ch1_o   = ch1_q;

endmodule

// File: doc/sample_averager.md
SAMPLE_AVERAGER -- requirements
Module: sample_averager

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 12, giving the per-channel sample width in bits.
REQ-002 The block SHALL have parameter LOG2_N, default 4, legal range 0..8, with N = 2^LOG2_N samples averaged per output.
REQ-003 Port clk_i  input  1  sole clock; all state SHALL change only on its rising edge, except under reset.
REQ-004 Port rst_n_i  input  1  asynchronous, active-low reset.
REQ-005 Port in_valid_i  input  1  a raw SPI read word is presented.
REQ-006 Port in_ready_o  output  1  the block accepts the word this cycle.
REQ-007 Port in_data_i  input  32  two-device SPI read word: ch0 in bits [DATA_WIDTH:1], ch1 in bits [16+DATA_WIDTH:17].
REQ-008 Port out_valid_o  output  1  averaged sample pair is available.
REQ-009 Port out_ready_i  input  1  downstream accepts the pair.
REQ-010 Port out_ch0_o  output  DATA_WIDTH  averaged channel 0.
REQ-011 Port out_ch1_o  output  DATA_WIDTH  averaged channel 1.

Function
REQ-012 An input transfer SHALL occur on a clk_i edge where in_valid_i and in_ready_o are both 1; an output transfer SHALL occur where out_valid_o and out_ready_i are both 1.
REQ-013 in_data_i bits [16:DATA_WIDTH+1] and [31:17+DATA_WIDTH] SHALL be ignored, including bit 0 and bit 16, which are tri-stated on the converter.
REQ-014 The block SHALL implement two states: ACCUM (in_ready_o=1, out_valid_o=0) and HOLD (in_ready_o=0, out_valid_o=1); both handshake outputs SHALL be registered or decoded only from state.
REQ-015 In ACCUM, each input transfer SHALL add the extracted ch0/ch1 values to per-channel accumulators of width DATA_WIDTH+LOG2_N and increment a sample counter of width LOG2_N+1.
REQ-016 On the input transfer that completes N samples, the state SHALL become HOLD on the same edge, and out_ch0_o/out_ch1_o SHALL be loaded with (sum + R) >> LOG2_N; R = 2^(LOG2_N-1) for LOG2_N>0, and R = 0 for LOG2_N=0; sum includes the current sample.
REQ-017 Latency from the final input transfer to out_valid_o=1 SHALL be exactly 1 clk_i cycle.
REQ-018 Rounded sums SHALL never overflow: accumulator plus R SHALL be held at DATA_WIDTH+LOG2_N+1 bits, and results SHALL saturate to 2^DATA_WIDTH-1.
REQ-019 In HOLD, out_ch0_o, out_ch1_o, and out_valid_o SHALL remain stable until an output transfer.
REQ-020 On an output transfer, the state SHALL return to ACCUM with accumulators and counter cleared; the next input transfer is possible no earlier than the following cycle (peak throughput one output per N+1 cycles).
REQ-021 in_valid_i asserted during HOLD SHALL be ignored and SHALL have no effect on state.
REQ-022 With LOG2_N=0, each accepted word SHALL produce one output equal to the extracted channel values.
REQ-023 Between transfers, outputs SHALL hold their last values; out_ch0_o and out_ch1_o SHALL be valid only while out_valid_o=1.

Reset
REQ-024 While rst_n_i=0, state SHALL be ACCUM and in_ready_o=1, out_valid_o=0, out_ch0_o=0, out_ch1_o=0, accumulators=0, counter=0, with effect independent of clk_i.
REQ-025 A reset asserted mid-accumulation or during HOLD SHALL discard all partial sums and any pending output; no output transfer SHALL follow from pre-reset samples.
REQ-026 Reset deassertion is synchronised externally; the first input transfer is allowed on the first clk_i edge after rst_n_i rises.

Verification
REQ-027 LOG2_N=0; in_data_i=32'h0246_1578, out_ready_i=1 -> one cycle later out_valid_o=1, out_ch0_o=12'hABC, out_ch1_o=12'h123.
REQ-028 LOG2_N=2; ch0 samples 10, 11, 12, 13 and ch1 samples 4095 x4 -> out_ch0_o=12 (46+2>>2), out_ch1_o=4095, with no overflow.
REQ-029 LOG2_N=2; ch0 samples 0, 0, 0, 2 -> out_ch0_o=1 (2+2>>2, round-half-up).
REQ-030 Completed average with out_ready_i=0 for 5 cycles and in_valid_i held 1 -> out_valid_o=1 with stable data, in_ready_o=0, no samples consumed; out_ready_i=1 -> transfer, then ACCUM next cycle.
REQ-031 LOG2_N=2; after 2 samples of value 500, pulse rst_n_i low asynchronously mid-cycle, then 4 samples of 100 -> single output of 100 on both channels.
REQ-032 Random in_valid_i/out_ready_i stalls over 10^4 words against a reference model -> every output equals the rounded mean of exactly N consecutive accepted words, with no loss or duplication.
